// File: rtl/mem_pkg.sv
// Shared definitions for the parameterised line-wide data memory:
// FSM state encoding, default geometry and the saturating counter helper.
package mem_pkg;

  localparam int LINE_W_DEF     = 256;
  localparam int ADDR_W_DEF     = 32;
  localparam int DEPTH_LOG2_DEF = 9;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK,
    S_RECOVER
  } mem_state_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/mem_latency_ctr.sv
// Loadable down-counter that times the WAIT phase of the memory FSM.
// zero_next tells the FSM that the counter is at (or is being loaded with) its final count.
module mem_latency_ctr
  import mem_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero_next
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  // Looking one step ahead lets the FSM leave WAIT on the edge where the count reaches zero.
  always_comb begin
    zero_next = 1'b0;
    if (load) begin
      zero_next = (load_val == '0);
    end else begin
      zero_next = (count <= CNT_W'(1));
    end
  end

endmodule

// File: rtl/data_memory_param.sv
// Line-wide data memory with a fixed request-to-ack latency, a one-cycle recovery
// slot between requests and saturating read/write completion counters.
module data_memory_param
  import mem_pkg::*;
#(
  parameter int LINE_W     = LINE_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter int LATENCY    = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [LINE_W-1:0] data_i,
  input  logic              enable_i,
  input  logic              write_i,
  output logic              ack_o,
  output logic [LINE_W-1:0] data_o,
  output logic              busy_o,
  output logic [31:0]       rd_cnt_o,
  output logic [31:0]       wr_cnt_o
);

  localparam int         OFF_W    = $clog2(LINE_W / 8);
  localparam int         DEPTH    = 2 ** DEPTH_LOG2;
  localparam logic [7:0] LOAD_VAL = 8'(LATENCY - 1);

  mem_state_t state, state_next;

  logic [ADDR_W-1:0]     addr_q;
  logic [LINE_W-1:0]     data_q;
  logic                  write_q;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  accept;
  logic                  ctr_zero_next;
  logic [31:0]           rd_cnt_q, wr_cnt_q;
  logic                  addr_unused;

  reg [LINE_W-1:0] memory [0:DEPTH-1];

  assign accept      = (state == S_IDLE) && enable_i;
  assign idx         = addr_q[OFF_W +: DEPTH_LOG2];
  // Offset and high address bits are deliberately dropped: lines are aligned and the map wraps.
  assign addr_unused = ^addr_q;

  mem_latency_ctr #(
    .CNT_W(8)
  ) u_latency_ctr (
    .clk      (clk_i),
    .rst      (rst_i),
    .load     (accept),
    .dec      (state == S_WAIT),
    .load_val (LOAD_VAL),
    .zero_next(ctr_zero_next)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:    if (enable_i) state_next = ctr_zero_next ? S_ACK : S_WAIT;
      S_WAIT:    if (ctr_zero_next) state_next = S_ACK;
      S_ACK:     state_next = S_RECOVER;
      S_RECOVER: state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  always_comb begin
    ack_o  = 1'b0;
    busy_o = (state != S_IDLE);
    data_o = '0;
    if (state == S_ACK) begin
      ack_o = 1'b1;
      if (!write_q) data_o = memory[idx];
    end
  end

  // The captured request is the only thing the rest of the transaction looks at.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q  <= '0;
      data_q  <= '0;
      write_q <= 1'b0;
    end else if (accept) begin
      addr_q  <= addr_i;
      data_q  <= data_i;
      write_q <= write_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if ((state == S_ACK) && write_q) begin
      memory[idx] <= data_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else if (state == S_ACK) begin
      if (write_q) wr_cnt_q <= sat_inc(wr_cnt_q);
      else         rd_cnt_q <= sat_inc(rd_cnt_q);
    end
  end

  assign rd_cnt_o = rd_cnt_q;
  assign wr_cnt_o = wr_cnt_q;

endmodule

// File: tb/tb_data_memory_param.sv
// Self-checking bench for data_memory_param: directed vector table, randomized traffic
// against a line-array reference model, and hand sequences for hold, reset and latency-1 cases.
module tb_data_memory_param;
  import mem_pkg::*;

  localparam int LW  = LINE_W_DEF;
  localparam int AW  = ADDR_W_DEF;
  localparam int LAT = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] addr = '0;
  logic [LW-1:0] wdata = '0;
  logic          write = 1'b0;
  logic          en0 = 1'b0, en1 = 1'b0;
  logic          ack0, ack1, busy0, busy1;
  logic [LW-1:0] rdata0, rdata1;
  logic [31:0]   rc0, wc0, rc1, wc1;

  bit            sel = 1'b0;
  logic          ack_s, busy_s;
  logic [LW-1:0] rdata_s;
  logic [31:0]   rc_s, wc_s;

  assign ack_s   = sel ? ack1   : ack0;
  assign busy_s  = sel ? busy1  : busy0;
  assign rdata_s = sel ? rdata1 : rdata0;
  assign rc_s    = sel ? rc1    : rc0;
  assign wc_s    = sel ? wc1    : wc0;

  always #5 clk = ~clk;

  data_memory_param #(.LATENCY(LAT)) dut0 (
    .clk_i(clk), .rst_i(rst), .addr_i(addr), .data_i(wdata), .enable_i(en0), .write_i(write),
    .ack_o(ack0), .data_o(rdata0), .busy_o(busy0), .rd_cnt_o(rc0), .wr_cnt_o(wc0)
  );

  data_memory_param #(.LATENCY(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .addr_i(addr), .data_i(wdata), .enable_i(en1), .write_i(write),
    .ack_o(ack1), .data_o(rdata1), .busy_o(busy1), .rd_cnt_o(rc1), .wr_cnt_o(wc1)
  );

  int compared = 0;
  int mismatched = 0;

  logic [LW-1:0] ref_mem [2][512];
  logic [31:0]   exp_rc [2];
  logic [31:0]   exp_wc [2];

  typedef struct {
    bit          wr;
    logic [31:0] a;
    logic [LW-1:0] d;
    logic [LW-1:0] exp;
  } vec_t;

  vec_t vecs [9];

  function automatic int lineIdx(input logic [31:0] a);
    return int'((a / 32'd32) % 32'd512);
  endfunction

  function automatic logic [LW-1:0] patt(input int i);
    logic [31:0] w;
    w = 32'hA5A5_0000 | 32'(i);
    return {8{w}};
  endfunction

  function automatic logic [31:0] modelInc(input logic [31:0] c);
    if (c == 32'hFFFF_FFFF) return c;
    return c + 32'd1;
  endfunction

  task automatic checkOutput(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One complete transaction on the selected DUT; returns the line seen on data_o at ack.
  task automatic applyStimulus(input bit wr, input logic [31:0] a, input logic [LW-1:0] d,
                               output logic [LW-1:0] seen);
    int            lat;
    int            expLat;
    int            i;
    logic [LW-1:0] expData;
    i       = lineIdx(a);
    expLat  = sel ? 1 : LAT;
    expData = wr ? '0 : ref_mem[sel][i];
    addr  = a;
    wdata = d;
    write = wr;
    if (sel) en1 = 1'b1; else en0 = 1'b1;
    @(posedge clk); #1;
    en0 = 1'b0;
    en1 = 1'b0;
    addr  = $urandom;
    wdata = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    write = 1'($urandom_range(0, 1));
    if (!sel) checkOutput("busy_wait", busy_s, 1'b1);
    lat = 1;
    while (!ack_s && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("latency", lat, expLat);
    seen = rdata_s;
    checkOutput("rdata", rdata_s, expData);
    if (wr) begin
      ref_mem[sel][i] = d;
      exp_wc[sel] = modelInc(exp_wc[sel]);
    end else begin
      exp_rc[sel] = modelInc(exp_rc[sel]);
    end
    @(posedge clk); #1;
    checkOutput("ack_pulse", ack_s, 1'b0);
    checkOutput("rd_cnt", rc_s, exp_rc[sel]);
    checkOutput("wr_cnt", wc_s, exp_wc[sel]);
    @(posedge clk); #1;
    checkOutput("busy_idle", busy_s, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [LW-1:0] seen;
    logic [31:0]   ra;
    int            ackCyc [4];
    int            nAck;
    int            lowCnt;
    int            stray;
    int            guard;

    for (int i = 0; i < 512; i++) begin
      dut0.memory[i] = patt(i);
      dut1.memory[i] = patt(i);
      ref_mem[0][i]  = patt(i);
      ref_mem[1][i]  = patt(i);
    end
    dut0.memory[0] = 256'h5;
    ref_mem[0][0]  = 256'h5;
    exp_rc = '{32'd0, 32'd0};
    exp_wc = '{32'd0, 32'd0};

    vecs[0] = '{wr: 1'b0, a: 32'h0000_0000, d: '0,          exp: 256'h5};
    vecs[1] = '{wr: 1'b1, a: 32'h0000_0400, d: 256'hAB,     exp: '0};
    vecs[2] = '{wr: 1'b0, a: 32'h0000_0400, d: '0,          exp: 256'hAB};
    vecs[3] = '{wr: 1'b1, a: 32'h0000_0000, d: 256'h11,     exp: '0};
    vecs[4] = '{wr: 1'b0, a: 32'h0000_4000, d: '0,          exp: 256'h11};
    vecs[5] = '{wr: 1'b0, a: 32'h0000_041F, d: '0,          exp: 256'hAB};
    vecs[6] = '{wr: 1'b1, a: 32'hFFFF_FFE0, d: {4{64'hDEAD_BEEF_0123_4567}}, exp: '0};
    vecs[7] = '{wr: 1'b0, a: 32'h0000_3FE0, d: '0,          exp: {4{64'hDEAD_BEEF_0123_4567}}};
    vecs[8] = '{wr: 1'b0, a: 32'h0000_0020, d: '0,          exp: {8{32'hA5A5_0001}}};

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_ack", ack0, 1'b0);
    checkOutput("reset_busy", busy0, 1'b0);
    checkOutput("reset_data", rdata0, '0);
    checkOutput("reset_rd_cnt", rc0, 32'd0);
    checkOutput("reset_wr_cnt", wc0, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] directed vector table");
    sel = 1'b0;
    for (int v = 0; v < 9; v++) begin
      applyStimulus(vecs[v].wr, vecs[v].a, vecs[v].d, seen);
      checkOutput($sformatf("vec%0d_data", v), seen, vecs[v].exp);
      if (v == 2) checkOutput("mem32", dut0.memory[32], 256'hAB);
    end

    $display("[TB] randomized traffic");
    for (int t = 0; t < 30; t++) begin
      ra = $urandom;
      if ($urandom_range(0, 1) == 1) ra = (ra & 32'hFFFF_C01F) | (32'($urandom_range(0, 3)) << 5);
      applyStimulus(1'($urandom_range(0, 1)), ra,
                    {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                    seen);
    end

    $display("[TB] enable held high");
    addr  = 32'h0;
    write = 1'b0;
    en0   = 1'b1;
    nAck   = 0;
    lowCnt = 0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      if (ack0) begin
        if (nAck < 4) ackCyc[nAck] = c;
        nAck++;
      end
      if (nAck == 1 && !busy0) lowCnt++;
    end
    en0 = 1'b0;
    checkOutput("hold_acks", nAck, 2);
    checkOutput("hold_gap", (nAck >= 2) ? ackCyc[1] - ackCyc[0] : 0, LAT + 2);
    checkOutput("hold_idle_gap", lowCnt, 1);
    guard = 0;
    while (busy0 && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("hold_drain", busy0, 1'b0);
    repeat (3) exp_rc[0] = modelInc(exp_rc[0]);
    checkOutput("hold_rd_cnt", rc0, exp_rc[0]);

    $display("[TB] reset during pending write");
    addr  = 32'h0000_0800;
    wdata = {8{32'h5A5A_C3C3}};
    write = 1'b1;
    en0   = 1'b1;
    @(posedge clk); #1;
    en0 = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst_busy", busy0, 1'b0);
    checkOutput("rst_ack", ack0, 1'b0);
    checkOutput("rst_wr_cnt", wc0, 32'd0);
    checkOutput("rst_rd_cnt", rc0, 32'd0);
    #1;
    rst = 1'b0;
    exp_rc = '{32'd0, 32'd0};
    exp_wc = '{32'd0, 32'd0};
    stray = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (ack0 || busy0) stray++;
    end
    checkOutput("rst_no_ack", stray, 0);
    checkOutput("rst_mem64", dut0.memory[64], ref_mem[0][64]);

    $display("[TB] latency-1 instance and saturation");
    sel = 1'b1;
    applyStimulus(1'b0, 32'h0000_0020, '0, seen);
    applyStimulus(1'b1, 32'h0000_0040, 256'h77, seen);
    applyStimulus(1'b0, 32'h0004_0040, '0, seen);
    checkOutput("lat1_alias", seen, 256'h77);
    dut1.rd_cnt_q = 32'hFFFF_FFFF;
    dut1.wr_cnt_q = 32'hFFFF_FFFF;
    exp_rc[1] = 32'hFFFF_FFFF;
    exp_wc[1] = 32'hFFFF_FFFF;
    applyStimulus(1'b0, 32'h0000_0060, '0, seen);
    applyStimulus(1'b1, 32'h0000_0060, 256'h99, seen);
    checkOutput("sat_rd", rc1, 32'hFFFF_FFFF);
    checkOutput("sat_wr", wc1, 32'hFFFF_FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
